// File: rtl/rhd_pkg.sv
// Shared constants and types for the RHD MISO capture path.
// With RHD_MISO_DDR_EN defined each lane carries {fall word, rise word}.
package rhd_pkg;

  localparam int NUM_LINES   = 8;
  localparam int WORD_W      = 16;
  localparam int DELAY_W     = 4;
  localparam int SYNC_STAGES = 2;
  localparam int DELAY_TAPS  = 1 << DELAY_W;
  localparam int BITCNT_W    = $clog2(WORD_W + 1);

`ifdef RHD_MISO_DDR_EN
  localparam int LANE_W = 2 * WORD_W;
`else
  localparam int LANE_W = WORD_W;
`endif

  localparam int FRAME_W = NUM_LINES * LANE_W;

  typedef logic [WORD_W-1:0]  rhd_word_t;
  typedef logic [DELAY_W-1:0] rhd_delay_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rhd_lane_state_e;

endpackage

// File: rtl/rhd_miso_lane.sv
// One MISO line: synchroniser, per-line strobe delay, 16-bit MSB-first shifter; word held until taken.
// Under RHD_MISO_DDR_EN a second shifter captures the fall-strobe bit; done needs both shifters full.
module rhd_miso_lane
  import rhd_pkg::*;
(
  input  logic               aclk,
  input  logic               areset,
  input  logic               enable,
  input  logic [DELAY_W-1:0] delay_cfg,
  input  logic               word_start,
  input  logic               sample_tick,
`ifdef RHD_MISO_DDR_EN
  input  logic               sample_tick_fall,
`endif
  input  logic               miso,
  input  logic               frame_take,
  output logic               done,
  output logic [LANE_W-1:0]  word
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   miso_s;

  always_ff @(posedge aclk) begin
    if (areset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], miso};
    end
  end

  assign miso_s = sync_q[SYNC_STAGES-1];

  // The word_start that latches a new delay must already use it, so bypass the latch on that cycle.
  rhd_delay_t dly_q;
  rhd_delay_t dly;

  always_ff @(posedge aclk) begin
    if (areset) begin
      dly_q <= '0;
    end else if (word_start) begin
      dly_q <= delay_cfg;
    end
  end

  assign dly = word_start ? delay_cfg : dly_q;

  // Tap k of each line is the strobe delayed by k cycles; tap 0 is the live input.
  logic [DELAY_TAPS-2:0] start_q;
  logic [DELAY_TAPS-2:0] tick_q;
  logic [DELAY_TAPS-1:0] start_tap;
  logic [DELAY_TAPS-1:0] tick_tap;
  logic                  start_d;
  logic                  tick_d;

  assign start_tap = {start_q, word_start};
  assign tick_tap  = {tick_q, sample_tick};
  assign start_d   = start_tap[dly];
  assign tick_d    = tick_tap[dly];

  always_ff @(posedge aclk) begin
    if (areset || !enable) begin
      start_q <= '0;
      tick_q  <= '0;
    end else begin
      start_q <= start_tap[DELAY_TAPS-2:0];
      tick_q  <= tick_tap[DELAY_TAPS-2:0];
    end
  end

  rhd_lane_state_e       state;
  rhd_word_t             sr;
  logic [BITCNT_W-1:0]   bitcnt;

  // A start strobe always wins: it restarts from bit 15 whatever state the lane is in.
  always_ff @(posedge aclk) begin
    if (areset || !enable) begin
      state  <= IDLE;
      sr     <= '0;
      bitcnt <= '0;
    end else if (start_d) begin
      state  <= SHIFT;
      sr     <= {{(WORD_W-1){1'b0}}, miso_s};
      bitcnt <= BITCNT_W'(1);
    end else begin
      case (state)
        SHIFT: begin
          if (tick_d) begin
            sr     <= {sr[WORD_W-2:0], miso_s};
            bitcnt <= bitcnt + BITCNT_W'(1);
            if (bitcnt == BITCNT_W'(WORD_W - 1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (frame_take) begin
            state <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RHD_MISO_DDR_EN
  logic [DELAY_TAPS-2:0] fall_q;
  logic [DELAY_TAPS-1:0] fall_tap;
  logic                  fall_d;
  rhd_word_t             fall_sr;
  logic [BITCNT_W-1:0]   fall_cnt;
  logic                  fall_done;

  assign fall_tap = {fall_q, sample_tick_fall};
  assign fall_d   = fall_tap[dly];

  // The fall strobe trails the rise strobe by half a bit, so it is armed by the rise start.
  always_ff @(posedge aclk) begin
    if (areset || !enable) begin
      fall_q    <= '0;
      fall_sr   <= '0;
      fall_cnt  <= '0;
      fall_done <= 1'b0;
    end else begin
      fall_q <= fall_tap[DELAY_TAPS-2:0];
      if (start_d) begin
        fall_sr   <= '0;
        fall_cnt  <= '0;
        fall_done <= 1'b0;
      end else if (state != IDLE && !fall_done && fall_d) begin
        fall_sr  <= {fall_sr[WORD_W-2:0], miso_s};
        fall_cnt <= fall_cnt + BITCNT_W'(1);
        if (fall_cnt == BITCNT_W'(WORD_W - 1)) begin
          fall_done <= 1'b1;
        end
      end else if (state == DONE && frame_take) begin
        fall_done <= 1'b0;
      end
    end
  end

  assign done = (state == DONE) && fall_done;
  assign word = {fall_sr, sr};
`else
  assign done = (state == DONE);
  assign word = sr;
`endif

endmodule

// File: rtl/rhd_miso_deserializer.sv
// RHD SPI MISO capture: NUM_LINES lanes, one frame per word; m_valid one cycle after the last lane completes.
// Frame arriving while output held (m_valid && !m_ready) is dropped and sets sticky overflow. RHD_MISO_DDR_EN adds fall capture.
module rhd_miso_deserializer
  import rhd_pkg::*;
(
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         enable,
  input  logic [NUM_LINES*DELAY_W-1:0] delay_cfg,
  input  logic                         word_start,
  input  logic                         sample_tick,
`ifdef RHD_MISO_DDR_EN
  input  logic                         sample_tick_fall,
`endif
  input  logic [NUM_LINES-1:0]         miso,
  output logic [FRAME_W-1:0]           m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         overflow,
  input  logic                         clear_overflow
);

  logic [NUM_LINES-1:0] lane_done;
  logic [FRAME_W-1:0]   frame;
  logic                 frame_take;
  logic                 load_ok;

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_lane
    rhd_miso_lane u_lane (
      .aclk             (aclk),
      .areset           (areset),
      .enable           (enable),
      .delay_cfg        (delay_cfg[i*DELAY_W +: DELAY_W]),
      .word_start       (word_start),
      .sample_tick      (sample_tick),
`ifdef RHD_MISO_DDR_EN
      .sample_tick_fall (sample_tick_fall),
`endif
      .miso             (miso[i]),
      .frame_take       (frame_take),
      .done             (lane_done[i]),
      .word             (frame[i*LANE_W +: LANE_W])
    );
  end

  // Lanes always return to IDLE on completion, whether the frame is loaded or dropped.
  assign frame_take = enable && (&lane_done);
  assign load_ok    = !m_valid || m_ready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      m_data   <= '0;
      m_valid  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (frame_take && load_ok) begin
        m_data  <= frame;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      if (frame_take && !load_ok) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rhd_miso_deserializer.sv
// Bench for rhd_miso_deserializer: random words and delays, frames compared against a per-lane word model.
// Build with RHD_MISO_DDR_EN to also cover the fall-strobe capture.
module tb_rhd_miso_deserializer;
  import rhd_pkg::*;

  localparam int NL = NUM_LINES;
  localparam int W  = WORD_W;
  localparam int LW = LANE_W;
  localparam int FW = FRAME_W;

  logic                    aclk;
  logic                    areset;
  logic                    enable;
  logic [NL*DELAY_W-1:0]   delay_cfg;
  logic                    word_start;
  logic                    sample_tick;
`ifdef RHD_MISO_DDR_EN
  logic                    sample_tick_fall;
`endif
  logic [NL-1:0]           miso;
  logic [FW-1:0]           m_data;
  logic                    m_valid;
  logic                    m_ready;
  logic                    overflow;
  logic                    clear_overflow;

  rhd_miso_deserializer dut (
    .aclk             (aclk),
    .areset           (areset),
    .enable           (enable),
    .delay_cfg        (delay_cfg),
    .word_start       (word_start),
    .sample_tick      (sample_tick),
`ifdef RHD_MISO_DDR_EN
    .sample_tick_fall (sample_tick_fall),
`endif
    .miso             (miso),
    .m_data           (m_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .overflow         (overflow),
    .clear_overflow   (clear_overflow)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  logic [W-1:0]  rise_w [NL];
  logic [W-1:0]  fall_w [NL];
  logic [FW-1:0] got_q [$];
  int            stab_err = 0;

  int            vld_rise_rel;
  logic          snap_vld;
  logic          snap_ovf;
  logic [FW-1:0] snap_data;

  // Monitor: records accepted frames and any change of a frame held under backpressure.
  logic          hold_prev = 1'b0;
  logic [FW-1:0] data_prev = '0;
  always @(negedge aclk) begin
    if (areset) begin
      hold_prev <= 1'b0;
    end else begin
      if (hold_prev && (!m_valid || m_data !== data_prev)) stab_err <= stab_err + 1;
      if (m_valid && m_ready) got_q.push_back(m_data);
      hold_prev <= m_valid && !m_ready;
      data_prev <= m_data;
    end
  end

  function automatic logic [FW-1:0] build_frame();
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < NL; i++) begin
      f[i*LW +: W] = rise_w[i];
`ifdef RHD_MISO_DDR_EN
      f[i*LW + W +: W] = fall_w[i];
`endif
    end
    return f;
  endfunction

  task automatic rand_words();
    for (int i = 0; i < NL; i++) begin
      rise_w[i] = 16'($urandom);
      fall_w[i] = 16'($urandom);
    end
  endtask

  task automatic rand_delays();
    for (int i = 0; i < NL; i++) delay_cfg[i*DELAY_W +: DELAY_W] = 4'($urandom_range(0, 15));
  endtask

  // One SPI word slot. Bit n of line i is held on miso so the lane, after its own delay and the
  // synchroniser, samples the rise word in the first half of the bit and the fall word in the second.
  // ready_mode: 0 random, 1 held low, 2 held high.
  task automatic run_slot(input int abort_ticks, input int ready_mode, input int en_off_at, input int rst_at);
    int   s0;
    int   len;
    logic vld_prev;
    s0 = 4 + 4 * abort_ticks;
    len = s0 + 80;
    vld_rise_rel = -1;
    vld_prev = 1'b1;
    for (int rel = 0; rel < len; rel++) begin
      @(posedge aclk);
      #1;
      if (!vld_prev && m_valid && vld_rise_rel < 0 && rel >= s0 + 8) vld_rise_rel = rel;
      vld_prev = m_valid;
      if (rst_at >= 0 && rel == rst_at + 3) begin
        snap_vld  = m_valid;
        snap_ovf  = overflow;
        snap_data = m_data;
      end
      word_start  = (rel == 4) || (rel == s0);
      sample_tick = (rel >= 4 && rel < s0 && (rel - 4) % 4 == 0) ||
                    (rel >= s0 && rel < s0 + 64 && (rel - s0) % 4 == 0);
`ifdef RHD_MISO_DDR_EN
      sample_tick_fall = (rel >= 6 && rel < s0 + 2 && (rel - 6) % 4 == 0) ||
                         (rel >= s0 + 2 && rel < s0 + 66 && (rel - s0 - 2) % 4 == 0);
`endif
      for (int i = 0; i < NL; i++) begin
        int d;
        int k;
        d = int'(delay_cfg[i*DELAY_W +: DELAY_W]);
        k = rel - (s0 - 2) - d;
        if (k >= 0 && k < 64) miso[i] = ((k % 4) < 2) ? rise_w[i][15 - k / 4] : fall_w[i][15 - k / 4];
        else miso[i] = 1'($urandom);
      end
      case (ready_mode)
        0:       m_ready = 1'($urandom);
        1:       m_ready = 1'b0;
        default: m_ready = 1'b1;
      endcase
      enable = !(en_off_at >= 0 && rel >= en_off_at && rel < en_off_at + 10);
      areset = (rst_at >= 0 && rel >= rst_at && rel < rst_at + 3);
    end
  endtask

  task automatic drain(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge aclk);
      #1;
      word_start  = 1'b0;
      sample_tick = 1'b0;
`ifdef RHD_MISO_DDR_EN
      sample_tick_fall = 1'b0;
`endif
      miso           = NL'($urandom);
      m_ready        = 1'b1;
      enable         = 1'b1;
      areset         = 1'b0;
      clear_overflow = 1'b0;
    end
  endtask

  task automatic test_reset();
    areset = 1'b1; enable = 1'b0; delay_cfg = '0; word_start = 1'b0; sample_tick = 1'b0;
`ifdef RHD_MISO_DDR_EN
    sample_tick_fall = 1'b0;
`endif
    miso = '0; m_ready = 1'b0; clear_overflow = 1'b0;
    repeat (4) @(posedge aclk);
    #1;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (m_data !== '0) begin failures++; $display("FAIL reset_data: got %0h expected 0", m_data); end
    areset = 1'b0;
    enable = 1'b1;
    drain(4);
  endtask

  task automatic test_basic();
    logic [FW-1:0] f;
    int base;
    base = got_q.size();
    delay_cfg = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < NL; i++) begin
        rise_w[i] = 16'hA5C3;
        fall_w[i] = 16'($urandom);
      end
      f = build_frame();
      run_slot(0, 2, -1, -1);
      // Last tick at rel 64 -> lane DONE, completion next cycle, m_valid visible at rel 66.
      checks++; if (vld_rise_rel !== 66) begin failures++; $display("FAIL basic_latency: got rel %0d expected 66", vld_rise_rel); end
      drain(2);
      checks++;
      if (got_q.size() != base + s + 1) begin failures++; $display("FAIL basic_count: got %0d expected %0d", got_q.size() - base, s + 1); end
      else if (got_q[base + s] !== f) begin failures++; $display("FAIL basic_frame: got %0h expected %0h", got_q[base + s], f); end
    end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL basic_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_delays();
    logic [FW-1:0] exp_q [$];
    int base;
    base = got_q.size();
    delay_cfg = 32'h0000_F731;
    for (int i = 0; i < NL; i++) begin
      rise_w[i] = 16'h1000 + 16'(i);
      fall_w[i] = 16'($urandom);
    end
    exp_q.push_back(build_frame());
    run_slot(0, 0, -1, -1);
    for (int s = 0; s < 3; s++) begin
      rand_delays();
      rand_words();
      exp_q.push_back(build_frame());
      run_slot(0, 0, -1, -1);
    end
    drain(60);
    checks++; if (got_q.size() - base != exp_q.size()) begin failures++; $display("FAIL delays_count: got %0d expected %0d", got_q.size() - base, exp_q.size()); end
    for (int j = 0; j < exp_q.size() && base + j < got_q.size(); j++) begin
      checks++; if (got_q[base + j] !== exp_q[j]) begin failures++; $display("FAIL delays_frame%0d: got %0h expected %0h", j, got_q[base + j], exp_q[j]); end
    end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL delays_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_overflow();
    logic [FW-1:0] fa;
    int base;
    base = got_q.size();
    rand_delays();
    rand_words();
    fa = build_frame();
    run_slot(0, 1, -1, -1);
    for (int s = 0; s < 2; s++) begin
      rand_words();
      run_slot(0, 1, -1, -1);
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL ovf_hold_valid: got %b expected 1", m_valid); end
    checks++; if (m_data !== fa) begin failures++; $display("FAIL ovf_hold_data: got %0h expected %0h", m_data, fa); end
    @(posedge aclk); #1;
    clear_overflow = 1'b1;
    @(posedge aclk); #1;
    clear_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL ovf_still_valid: got %b expected 1", m_valid); end
    m_ready = 1'b1;
    @(posedge aclk); #1;
    m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL ovf_accept: got valid %b expected 0", m_valid); end
    drain(10);
    checks++;
    if (got_q.size() - base != 1) begin failures++; $display("FAIL ovf_count: got %0d expected 1", got_q.size() - base); end
    else if (got_q[base] !== fa) begin failures++; $display("FAIL ovf_frame: got %0h expected %0h", got_q[base], fa); end
  endtask

  task automatic test_restart();
    logic [FW-1:0] f;
    int base;
    base = got_q.size();
    rand_delays();
    for (int i = 0; i < NL; i++) begin
      rise_w[i] = 16'h8001;
      fall_w[i] = 16'($urandom);
    end
    f = build_frame();
    run_slot(7, 2, -1, -1);
    drain(10);
    checks++;
    if (got_q.size() - base != 1) begin failures++; $display("FAIL restart_count: got %0d expected 1", got_q.size() - base); end
    else if (got_q[base] !== f) begin failures++; $display("FAIL restart_frame: got %0h expected %0h", got_q[base], f); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL restart_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] f;
    int base;
    base = got_q.size();
    rand_delays();
    for (int s = 0; s < 2; s++) begin
      rand_words();
      run_slot(0, 1, -1, -1);
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL rstmid_pre_overflow: got %b expected 1", overflow); end
    rand_words();
    run_slot(0, 1, -1, 30);
    checks++; if (snap_vld !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %b expected 0", snap_vld); end
    checks++; if (snap_ovf !== 1'b0) begin failures++; $display("FAIL rstmid_overflow: got %b expected 0", snap_ovf); end
    checks++; if (snap_data !== '0) begin failures++; $display("FAIL rstmid_data: got %0h expected 0", snap_data); end
    rand_words();
    f = build_frame();
    run_slot(0, 2, -1, -1);
    drain(10);
    checks++;
    if (got_q.size() - base != 1) begin failures++; $display("FAIL rstmid_count: got %0d expected 1", got_q.size() - base); end
    else if (got_q[base] !== f) begin failures++; $display("FAIL rstmid_frame: got %0h expected %0h", got_q[base], f); end
  endtask

  task automatic test_enable();
    logic [FW-1:0] fa;
    logic [FW-1:0] fc;
    int base;
    base = got_q.size();
    rand_delays();
    rand_words();
    fa = build_frame();
    run_slot(0, 1, -1, -1);
    rand_words();
    run_slot(0, 0, 30, -1);
    rand_words();
    fc = build_frame();
    run_slot(0, 2, -1, -1);
    drain(10);
    checks++;
    if (got_q.size() - base != 2) begin failures++; $display("FAIL enable_count: got %0d expected 2", got_q.size() - base); end
    else begin
      if (got_q[base] !== fa) begin failures++; $display("FAIL enable_drain: got %0h expected %0h", got_q[base], fa); end
      checks++;
      if (got_q[base + 1] !== fc) begin failures++; $display("FAIL enable_resume: got %0h expected %0h", got_q[base + 1], fc); end
    end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL enable_overflow: got %b expected 0", overflow); end
  endtask

`ifdef RHD_MISO_DDR_EN
  task automatic test_ddr();
    logic [FW-1:0] f;
    int base;
    base = got_q.size();
    rand_delays();
    for (int i = 0; i < NL; i++) begin
      rise_w[i] = 16'h1234;
      fall_w[i] = 16'hABCD;
    end
    f = build_frame();
    run_slot(0, 2, -1, -1);
    drain(10);
    checks++;
    if (got_q.size() - base != 1) begin failures++; $display("FAIL ddr_count: got %0d expected 1", got_q.size() - base); end
    else if (got_q[base] !== f) begin failures++; $display("FAIL ddr_frame: got %0h expected %0h", got_q[base], f); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_delays();
    test_overflow();
    test_restart();
    test_reset_mid();
    test_enable();
`ifdef RHD_MISO_DDR_EN
    test_ddr();
`endif
    drain(4);
    checks++; if (stab_err != 0) begin failures++; $display("FAIL hold_stability: got %0d changes expected 0", stab_err); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
